// File: rtl/vec_mac_array_pkg.sv
// vec_mac_array_pkg
//   Shared sizing for the vector MAC array and its lanes. The top level and
//   the lane take their parameter defaults from here, so the three sizes
//   are defined in exactly one place.
//   Contents:
//     channel_num_default - number of independent lanes
//     val_bits_default    - width of one vector / matrix value
//     acc_bits_default    - width of the accumulator and of a row result
//     mat_lane_bits()     - width of one matrix FIFO word ({row_end, value})
package vec_mac_array_pkg;

  localparam int channel_num_default = 4;
  localparam int val_bits_default    = 8;
  localparam int acc_bits_default    = 32;

  function automatic int mat_lane_bits(input int val_bits);
    return val_bits + 1;
  endfunction

endpackage

// File: rtl/vec_mac_lane.sv
// vec_mac_lane
//   One lane of the MAC array: pops paired vector/matrix elements from two
//   standard-read FIFOs, multiplies them, accumulates over a row and holds
//   the row result until it is accepted.
//   Ports:
//     clk, rst      - clock, synchronous active-high reset
//     vec_val       - vector FIFO dout
//     vec_empty     - vector FIFO empty
//     mat_val       - matrix FIFO dout, value part
//     mat_row_end   - matrix FIFO dout, row_end flag
//     mat_empty     - matrix FIFO empty
//     read          - rd_en for both FIFOs (one strobe, so they can never differ)
//     result        - row dot product, saturated to acc_bits
//     result_valid  - result held until result_ready
//     result_ready  - result accepted
//     overflow      - sticky: some accumulate saturated since reset
//
//   Handshake: a result is transferred in a cycle where result_valid and
//   result_ready are both 1; result_valid falls in the following cycle and
//   result stays stable for as long as result_valid is high.
//
//   Timing for a pop in cycle N: FIFO douts appear in N+1 (stage 1, tracked by
//   s1_valid); the product is registered at the end of N+1 (stage 2); the
//   accumulate happens at the end of N+2, so a row_end result is visible in N+3.
module vec_mac_lane
  import vec_mac_array_pkg::*;
#(
  parameter int val_bits = val_bits_default,
  parameter int acc_bits = acc_bits_default
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [val_bits-1:0] vec_val,
  input  logic                vec_empty,
  input  logic [val_bits-1:0] mat_val,
  input  logic                mat_row_end,
  input  logic                mat_empty,
  output logic                read,
  output logic [acc_bits-1:0] result,
  output logic                result_valid,
  input  logic                result_ready,
  output logic                overflow
);

  logic                  s1_valid;
  logic                  s2_valid;
  logic                  s2_row_end;
  logic [acc_bits-1:0]   s2_prod;
  logic [acc_bits-1:0]   acc;
  logic [2*val_bits-1:0] prod;
  logic [acc_bits:0]     sum;
  logic [acc_bits-1:0]   sum_sat;

  // A row_end element still in the pipeline blocks further pops so the next
  // row cannot start accumulating before this row's result is parked.
  // In stage 1 the row_end flag is only available straight off the FIFO dout.
  always_comb begin
    read = ~rst & ~vec_empty & ~mat_empty & ~result_valid
         & ~(s1_valid & mat_row_end) & ~(s2_valid & s2_row_end);
  end

  assign prod    = (2*val_bits)'(vec_val) * (2*val_bits)'(mat_val);
  assign sum     = {1'b0, acc} + {1'b0, s2_prod};
  assign sum_sat = sum[acc_bits] ? '1 : sum[acc_bits-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid     <= 1'b0;
      s2_valid     <= 1'b0;
      s2_row_end   <= 1'b0;
      s2_prod      <= '0;
      acc          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      s1_valid   <= read;
      s2_valid   <= s1_valid;
      s2_row_end <= s1_valid & mat_row_end;
      if (s1_valid) begin
        s2_prod <= acc_bits'(prod);
      end

      if (result_valid && result_ready) begin
        result_valid <= 1'b0;
      end

      if (s2_valid) begin
        if (sum[acc_bits]) begin
          overflow <= 1'b1;
        end
        if (s2_row_end) begin
          result       <= sum_sat;
          acc          <= '0;
          result_valid <= 1'b1;
        end else begin
          acc <= sum_sat;
        end
      end
    end
  end

endmodule

// File: rtl/vec_mac_array.sv
// vec_mac_array
//   channel_num independent MAC lanes, each dotting a vector stream with a
//   matrix row stream and producing one saturated result per row.
//   Ports (lane f occupies slice f of every bus):
//     clk, rst        - clock, synchronous active-high reset
//     vec             - vector FIFO douts, val_bits per lane
//     vec_fifo_empty  - vector FIFO empties
//     vec_fifo_read   - vector FIFO rd_en
//     mat             - matrix FIFO douts, {row_end, value} per lane
//     mat_fifo_empty  - matrix FIFO empties
//     mat_fifo_read   - matrix FIFO rd_en
//     result          - row results, acc_bits per lane
//     result_valid    - per-lane result valid
//     result_ready    - per-lane result accepted
//     overflow        - per-lane sticky saturation flag
module vec_mac_array
  import vec_mac_array_pkg::*;
#(
  parameter int channel_num = channel_num_default,
  parameter int val_bits    = val_bits_default,
  parameter int acc_bits    = acc_bits_default
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [channel_num*val_bits-1:0]     vec,
  input  logic [channel_num-1:0]              vec_fifo_empty,
  output logic [channel_num-1:0]              vec_fifo_read,
  input  logic [channel_num*(val_bits+1)-1:0] mat,
  input  logic [channel_num-1:0]              mat_fifo_empty,
  output logic [channel_num-1:0]              mat_fifo_read,
  output logic [channel_num*acc_bits-1:0]     result,
  output logic [channel_num-1:0]              result_valid,
  input  logic [channel_num-1:0]              result_ready,
  output logic [channel_num-1:0]              overflow
);

  localparam int mw = mat_lane_bits(val_bits);

  for (genvar f = 0; f < channel_num; f++) begin : g_lane
    logic rd;

    vec_mac_lane #(
      .val_bits(val_bits),
      .acc_bits(acc_bits)
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .vec_val     (vec[f*val_bits +: val_bits]),
      .vec_empty   (vec_fifo_empty[f]),
      .mat_val     (mat[f*mw +: val_bits]),
      .mat_row_end (mat[f*mw + val_bits]),
      .mat_empty   (mat_fifo_empty[f]),
      .read        (rd),
      .result      (result[f*acc_bits +: acc_bits]),
      .result_valid(result_valid[f]),
      .result_ready(result_ready[f]),
      .overflow    (overflow[f])
    );

    // Both FIFOs of a lane are popped from the same strobe.
    assign vec_fifo_read[f] = rd;
    assign mat_fifo_read[f] = rd;
  end

endmodule
